// File: rtl/mult_seq_residue.sv
// Sequential shift-add unsigned multiplier with an optional mod-3 residue checker.
// One operation runs IDLE -> RUN (WIDTH cycles) -> CHECK -> DONE -> IDLE.
module mult_seq_residue #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned RESIDUE_CHECK = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               inject,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               fault
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;

    logic [PW-1:0]   addend;
    logic [PW-1:0]   run_sum;
    logic [PW-1:0]   run_next;
    logic            first_run;

    assign addend    = mplier_q[0] ? mcand_q : '0;
    assign run_sum   = acc_q + addend;
    // The counter still holds WIDTH only during the first RUN cycle.
    assign first_run = (cnt_q == CW'(WIDTH));
    assign run_next  = {run_sum[PW-1:1], run_sum[0] ^ (inject & first_run)};

    // Next-state and datapath update for the shift-add sequence.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_d    = run_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                product_d = acc_q;
                state_d   = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == StRun) || (state_q == StCheck);
    assign done    = (state_q == StDone);
    assign product = product_q;

    if (RESIDUE_CHECK != 0) begin : g_residue
        logic [1:0] re_q, re_d;
        logic       fault_q, fault_d;
        logic [1:0] ra, rb, re_new, acc_res;
        logic [3:0] rr;

        // Bit-serial mod-3 reduction, MSB first: r = (2r + bit) mod 3.
        function automatic logic [1:0] mod3(input logic [PW-1:0] v);
            logic [1:0] r;
            r = 2'd0;
            for (int i = PW - 1; i >= 0; i--) begin
                case ({r, v[i]})
                    3'b000:  r = 2'd0;
                    3'b001:  r = 2'd1;
                    3'b010:  r = 2'd2;
                    3'b011:  r = 2'd0;
                    3'b100:  r = 2'd1;
                    3'b101:  r = 2'd2;
                    default: r = 2'd0;
                endcase
            end
            return r;
        endfunction

        assign ra      = mod3({{WIDTH{1'b0}}, a});
        assign rb      = mod3({{WIDTH{1'b0}}, b});
        assign rr      = {2'b00, ra} * {2'b00, rb};
        assign re_new  = (rr >= 4'd3) ? 2'(rr - 4'd3) : rr[1:0];
        assign acc_res = mod3(acc_q);

        // Expected residue captured with the operands; verdict taken in CHECK.
        always_comb begin
            re_d    = re_q;
            fault_d = fault_q;
            if (state_q == StIdle && start) begin
                re_d = re_new;
            end
            if (state_q == StCheck) begin
                fault_d = (acc_res != re_q);
            end
        end

        // Residue checker registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                re_q    <= 2'd0;
                fault_q <= 1'b0;
            end else begin
                re_q    <= re_d;
                fault_q <= fault_d;
            end
        end

        assign fault = fault_q;
    end else begin : g_no_residue
        assign fault = 1'b0;
    end

endmodule

// File: tb/tb_mult_seq_residue.sv
// Self-checking bench for mult_seq_residue: directed scenarios and randomized
// operations on a WIDTH=4 and a WIDTH=8 instance against an arithmetic model.
module tb_mult_seq_residue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start4, inject4, busy4, done4, fault4;
    logic [3:0] a4, b4;
    logic [7:0] product4;
    logic       start8, inject8, busy8, done8, fault8;
    logic [7:0] a8, b8;
    logic [15:0] product8;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] last4 = '0;

    mult_seq_residue #(.WIDTH(4), .RESIDUE_CHECK(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .inject(inject4),
        .busy(busy4), .done(done4), .product(product4), .fault(fault4)
    );

    mult_seq_residue #(.WIDTH(8), .RESIDUE_CHECK(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .inject(inject8),
        .busy(busy8), .done(done8), .product(product8), .fault(fault8)
    );

    // Model: a*b; an injected flip of bit 0 after the first add (acc = a*b[0])
    // changes the result by -1 when that bit was 1, else +1; fault follows inject.
    function automatic int model_prod(input int a, input int b, input bit inj);
        int e;
        e = a * b;
        if (inj) e += ((a % 2 == 1) && (b % 2 == 1)) ? -1 : 1;
        return e;
    endfunction

    // Drive one W4 op (called just after a negedge) and observe 8 cycles.
    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic inj,
                           input int extra_at, output logic [7:0] prod, output logic flt,
                           output int done_at, output int done_cnt, output int seq_bad);
        done_at = 0; done_cnt = 0; seq_bad = 0; prod = '0; flt = 1'b0;
        start4 = 1'b1; a4 = a; b4 = b; inject4 = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (busy4 !== (i <= 5)) seq_bad++;
            if (i <= 5 && product4 !== last4) seq_bad++;
            if (done4 === 1'b1) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = i; prod = product4; flt = fault4;
                end
            end
            start4  = 1'b0;
            inject4 = (i == 1) ? inj : 1'b0;
            if (i == extra_at) begin
                start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
            end
        end
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic inj,
                           output logic [15:0] prod, output logic flt, output int done_at);
        done_at = 0; prod = '0; flt = 1'b0;
        start8 = 1'b1; a8 = a; b8 = b; inject8 = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1 && done_at == 0) begin
                done_at = i; prod = product8; flt = fault8;
            end
            start8  = 1'b0;
            inject8 = (i == 1) ? inj : 1'b0;
        end
    endtask

    // Checks one W4 op: result, fault, latency, single pulse, busy/hold pattern.
    task automatic check_op4(input string name, input logic [3:0] a, input logic [3:0] b,
                             input logic inj, input int extra_at);
        logic [7:0] p; logic f; int dat, dcnt, bad; logic [7:0] ep;
        ep = 8'(model_prod(int'(a), int'(b), inj));
        run_op4(a, b, inj, extra_at, p, f, dat, dcnt, bad);
        n_tests++;
        if (p !== ep || f !== inj) begin
            n_fail++;
            $display("FAIL %s: product=%0d fault=%0b, required product=%0d fault=%0b",
                     name, p, f, ep, inj);
        end
        n_tests++;
        if (dat != 6 || dcnt != 1 || bad != 0) begin
            n_fail++;
            $display("FAIL %s timing: done_at=%0d pulses=%0d busy/hold errors=%0d, required 6/1/0",
                     name, dat, dcnt, bad);
        end
        last4 = ep;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start4 = 0; inject4 = 0; a4 = 0; b4 = 0;
        start8 = 0; inject8 = 0; a8 = 0; b8 = 0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || product4 !== 8'd0 || fault4 !== 1'b0 ||
            busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'd0 || fault8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b product=%0d fault=%b, required all 0",
                     busy4, done4, product4, fault4);
        end
        rst_n = 1'b1;
        last4 = '0;
    endtask

    task automatic test_directed();
        check_op4("max_15x15", 4'd15, 4'd15, 1'b0, 0);
        check_op4("zero_7x0", 4'd7, 4'd0, 1'b0, 0);
        check_op4("zero_0x9", 4'd0, 4'd9, 1'b0, 0);
        check_op4("inject_6x5", 4'd6, 4'd5, 1'b1, 0);
        check_op4("clean_3x3", 4'd3, 4'd3, 1'b0, 0);
    endtask

    task automatic test_busy_start();
        check_op4("start_while_busy_9x9", 4'd9, 4'd9, 1'b0, 2);
        check_op4("start_in_done_5x7", 4'd5, 4'd7, 1'b0, 6);
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        start4 = 1'b1; a4 = 4'd5; b4 = 4'd5;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || product4 !== 8'd0 || fault4 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_reset: busy=%b done=%b product=%0d fault=%b, required 0",
                     busy4, done4, product4, fault4);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done4 === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0 || product4 !== 8'd0) begin
            n_fail++;
            $display("FAIL aborted_op: done pulses=%0d product=%0d, required 0/0",
                     pulses, product4);
        end
        last4 = '0;
        // Start immediately at the first edge after reset release.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_op4("after_reset_2x3", 4'd2, 4'd3, 1'b0, 0);
    endtask

    task automatic test_random4();
        logic [3:0] a, b; logic inj;
        for (int k = 0; k < 40; k++) begin
            a = 4'($urandom); b = 4'($urandom); inj = ($urandom_range(0, 3) == 0);
            check_op4("random_w4", a, b, inj, 0);
        end
    endtask

    task automatic test_w8();
        logic [7:0] a, b; logic inj; logic [15:0] p, ep; logic f; int dat;
        for (int k = 0; k < 1500; k++) begin
            case (k)
                0: begin a = 8'd255; b = 8'd255; end
                1: begin a = 8'd0;   b = 8'd0;   end
                2: begin a = 8'd255; b = 8'd0;   end
                3: begin a = 8'd1;   b = 8'd255; end
                default: begin a = 8'($urandom); b = 8'($urandom); end
            endcase
            inj = (k >= 4) && ($urandom_range(0, 7) == 0);
            ep = 16'(model_prod(int'(a), int'(b), inj));
            run_op8(a, b, inj, p, f, dat);
            n_tests++;
            if (p !== ep || f !== inj || dat != 10) begin
                n_fail++;
                $display("FAIL w8 %0dx%0d inj=%0b: product=%0d fault=%0b done_at=%0d, required %0d/%0b/10",
                         a, b, inj, p, f, dat, ep, inj);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_start();
        test_reset_mid_run();
        test_random4();
        test_w8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
